// File: rtl/axilm_pkg.sv
// axilm_pkg
// Shared types and constants for the AXI4-Lite write master (axilm_wr_pipe)
// and its channel holding register (axilm_ch_slot).
//   axi_resp_e    : AXI BRESP encodings
//   PROT_DEFAULT  : default value driven on AWPROT
//   strb_width()  : byte-strobe width for a given data width
package axilm_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axilm_wr_pipe_if.sv
// axilm_wr_pipe_if
// AXI4-Lite write-side bundle (AW, W and B channels).
//   master modport : drives AWADDR/AWPROT/AWVALID, WDATA/WSTRB/WVALID, BREADY
//   slave modport  : drives AWREADY, WREADY, BVALID/BRESP
// Parameters: ADDR_W address width, DATA_W data width (32 or 64).
interface axilm_wr_pipe_if
  import axilm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  localparam int STRB_W = strb_width(DATA_W);

  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BRESP;

  modport master (
    output AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BVALID, BRESP,
    output BREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BVALID, BRESP,
    input  BREADY
  );

endinterface

// File: rtl/axilm_ch_slot.sv
// axilm_ch_slot
// One-entry valid/payload holding register for a single AXI channel.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   load          : capture load_data and raise valid at the next edge
//   load_data     : payload to capture
//   ready         : channel ready from the slave
//   valid, data   : registered channel valid and payload
//   free          : slot can take a new load this cycle
module axilm_ch_slot #(
  parameter int W = 32
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  // Free when empty, or when the held beat is handshaking this cycle.
  assign free = ~valid | ready;

  // A load in the handshake cycle keeps valid high for back-to-back issue.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axilm_wr_pipe.sv
// axilm_wr_pipe
// Pipelined AXI4-Lite write master. Local write requests are accepted over a
// valid/ready handshake, AW and W are issued from independent holding slots,
// up to MAX_OUTS writes may be outstanding, and each BRESP is returned in
// order through a registered local response handshake.
//   ACLK, ARESETn                       : clock, asynchronous active-low reset
//   axi (master modport)                : AXI4-Lite AW/W/B channels
//   req_valid/req_ready                 : local request handshake
//   req_addr/req_wdata/req_wstrb        : request payload
//   rsp_valid/rsp_ready/rsp_resp        : local response handshake + BRESP
// Optional macro AXILM_WR_ERR_CNT_EN adds:
//   err_clr  : synchronous clear of the error counter (wins over increment)
//   err_cnt  : saturating count of SLVERR/DECERR responses
module axilm_wr_pipe
  import axilm_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter int         MAX_OUTS = 4,
  parameter logic [2:0] PROT     = PROT_DEFAULT,
  localparam int        STRB_W   = strb_width(DATA_W)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  axilm_wr_pipe_if.master   axi,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
`ifdef AXILM_WR_ERR_CNT_EN
  input  logic              err_clr,
  output logic [15:0]       err_cnt,
`endif
  output logic [1:0]        rsp_resp
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_OUTS);

  logic [3:0]               cnt;
  logic                     aw_free;
  logic                     w_free;
  logic                     accept;
  logic                     rsp_pop;
  logic                     b_hs;
  logic [DATA_W+STRB_W-1:0] w_payload;

  assign axi.AWPROT = PROT;
  assign rsp_pop    = rsp_valid & rsp_ready;

  // The response register is the only B buffer, so B is taken whenever it is
  // empty or being drained. Gated by reset so BREADY is low while in reset.
  assign axi.BREADY = ARESETn & (~rsp_valid | rsp_ready);
  assign b_hs       = axi.BVALID & axi.BREADY;

  // At the outstanding limit a same-cycle response pop frees a credit.
  assign req_ready = aw_free & w_free &
                     ((cnt < CNT_MAX) | ((cnt == CNT_MAX) & rsp_pop));
  assign accept    = req_valid & req_ready;

  axilm_ch_slot #(.W(ADDR_W)) u_aw_slot (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .load      (accept),
    .load_data (req_addr),
    .ready     (axi.AWREADY),
    .valid     (axi.AWVALID),
    .data      (axi.AWADDR),
    .free      (aw_free)
  );

  axilm_ch_slot #(.W(DATA_W + STRB_W)) u_w_slot (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .load      (accept),
    .load_data ({req_wstrb, req_wdata}),
    .ready     (axi.WREADY),
    .valid     (axi.WVALID),
    .data      (w_payload),
    .free      (w_free)
  );

  assign axi.WDATA = w_payload[DATA_W-1:0];
  assign axi.WSTRB = w_payload[DATA_W+STRB_W-1:DATA_W];

  // Writes in flight from accept until the local side pops the response.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt <= '0;
    end else begin
      unique case ({accept, rsp_pop})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // BREADY guarantees the register is empty or draining when B is taken.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rsp_valid <= 1'b0;
      rsp_resp  <= OKAY;
    end else if (b_hs) begin
      rsp_valid <= 1'b1;
      rsp_resp  <= axi.BRESP;
    end else if (rsp_pop) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef AXILM_WR_ERR_CNT_EN
  // BRESP[1] set means SLVERR or DECERR.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (b_hs && axi.BRESP[1] && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axilm_wr_pipe.sv
// tb_axilm_wr_pipe
// Self-checking bench for axilm_wr_pipe: directed scenarios followed by
// randomized traffic, checked against a queue-based transaction model.
module tb_axilm_wr_pipe;
  import axilm_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = 4;
  localparam int MAX_OUTS = 4;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_resp;
`ifdef AXILM_WR_ERR_CNT_EN
  logic              err_clr;
  logic [15:0]       err_cnt;
  int                err_model = 0;
`endif

  axilm_wr_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axilm_wr_pipe #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_OUTS (MAX_OUTS),
    .PROT     (3'b000)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .axi       (axi),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
`ifdef AXILM_WR_ERR_CNT_EN
    .err_clr   (err_clr),
    .err_cnt   (err_cnt),
`endif
    .rsp_resp  (rsp_resp)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  // Transaction model: every accepted request must appear once on AW and
  // once on W in accept order; every B response must come back locally in
  // B order; in-flight count = accepts - pops and never exceeds MAX_OUTS.
  logic [ADDR_W-1:0]        q_addr[$];
  logic [STRB_W+DATA_W-1:0] q_w[$];
  logic [1:0]               q_rsp[$];
  int model_cnt = 0;
  int acc_n = 0, pop_n = 0, aw_n = 0, w_n = 0, b_n = 0, req_left = 0;
  bit acc_last = 0, b_last = 0;
  int acc_base, pop_base;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    q_addr.delete();
    q_w.delete();
    q_rsp.delete();
    model_cnt = 0;
    aw_n = 0;
    w_n = 0;
    b_n = 0;
    acc_last = 0;
    b_last = 0;
`ifdef AXILM_WR_ERR_CNT_EN
    err_model = 0;
`endif
  endtask

  // Observe one cycle's handshakes at the negedge, update the model, then
  // advance to just after the next rising edge.
  task automatic tick();
    bit pop_now, acc_now, bhs_now;
    @(negedge ACLK);
    acc_last = 0;
    b_last   = 0;
    pop_now  = rsp_valid && rsp_ready;
    acc_now  = req_valid && req_ready;
    bhs_now  = axi.BVALID && axi.BREADY;
    if (model_cnt == MAX_OUTS && !pop_now)
      checkOutput("req_ready_at_limit", 64'(req_ready), 64'(0));
    if (acc_now) begin
      checkOutput("accept_within_limit", 64'(model_cnt < MAX_OUTS || pop_now), 64'(1));
      q_addr.push_back(req_addr);
      q_w.push_back({req_wstrb, req_wdata});
      acc_n++;
      acc_last = 1;
      if (req_left > 0) req_left--;
    end
    if (axi.AWVALID && axi.AWREADY) begin
      checkOutput("aw_expected", 64'(q_addr.size() != 0), 64'(1));
      if (q_addr.size() != 0) checkOutput("awaddr", 64'(axi.AWADDR), 64'(q_addr.pop_front()));
      checkOutput("awprot", 64'(axi.AWPROT), 64'(0));
      aw_n++;
    end
    if (axi.WVALID && axi.WREADY) begin
      checkOutput("w_expected", 64'(q_w.size() != 0), 64'(1));
      if (q_w.size() != 0) checkOutput("wdata_wstrb", 64'({axi.WSTRB, axi.WDATA}), 64'(q_w.pop_front()));
      w_n++;
    end
    if (pop_now) begin
      checkOutput("rsp_expected", 64'(q_rsp.size() != 0), 64'(1));
      if (q_rsp.size() != 0) checkOutput("rsp_resp_order", 64'(rsp_resp), 64'(q_rsp.pop_front()));
      pop_n++;
    end
    if (bhs_now) begin
      q_rsp.push_back(axi.BRESP);
      b_n++;
      b_last = 1;
    end
`ifdef AXILM_WR_ERR_CNT_EN
    if (err_clr) err_model = 0;
    else if (bhs_now && axi.BRESP[1] && err_model < 65535) err_model++;
`endif
    model_cnt = model_cnt + (acc_now ? 1 : 0) - (pop_now ? 1 : 0);
    @(posedge ACLK);
    #1;
`ifdef AXILM_WR_ERR_CNT_EN
    checkOutput("err_cnt", 64'(err_cnt), 64'(err_model));
`endif
  endtask

  // Drive one cycle of local requests, slave readies and B responses.
  // B is only offered for writes whose AW and W have both completed and is
  // held stable until taken.
  task automatic applyStimulus(input bit rnd, input bit b_en);
    int done_n;
    if (!(req_valid && !acc_last)) begin
      if (req_left > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        req_valid = 1'b1;
        req_addr  = $urandom & 32'hFFFF_FFFC;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    axi.AWREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    axi.WREADY  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    rsp_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    done_n = (aw_n < w_n) ? aw_n : w_n;
    if (!(axi.BVALID && !b_last)) begin
      if (b_en && done_n > b_n && (!rnd || $urandom_range(0, 1) != 0)) begin
        axi.BVALID = 1'b1;
        axi.BRESP  = 2'($urandom);
      end else begin
        axi.BVALID = 1'b0;
      end
    end
  endtask

  initial begin
    ARESETn     = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    rsp_ready   = 1'b0;
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = OKAY;
`ifdef AXILM_WR_ERR_CNT_EN
    err_clr     = 1'b0;
`endif
    #1 ARESETn = 1'b0;
    #11;

    // Reset values
    checkOutput("rst_awvalid", 64'(axi.AWVALID), 64'(0));
    checkOutput("rst_wvalid", 64'(axi.WVALID), 64'(0));
    checkOutput("rst_bready", 64'(axi.BREADY), 64'(0));
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("rst_awaddr", 64'(axi.AWADDR), 64'(0));
    checkOutput("rst_wdata", 64'(axi.WDATA), 64'(0));
    checkOutput("rst_wstrb", 64'(axi.WSTRB), 64'(0));
    checkOutput("rst_rsp_resp", 64'(rsp_resp), 64'(0));
`ifdef AXILM_WR_ERR_CNT_EN
    checkOutput("rst_err_cnt", 64'(err_cnt), 64'(0));
`endif
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    resetModel();

    // Single write, all ready, one-cycle latency on every stage
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    rsp_ready   = 1'b1;
    req_valid   = 1'b1;
    req_addr    = 32'h0000_1000;
    req_wdata   = 32'hDEAD_BEEF;
    req_wstrb   = 4'hF;
    #1 checkOutput("t1_req_ready", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    checkOutput("t1_awvalid", 64'(axi.AWVALID), 64'(1));
    checkOutput("t1_wvalid", 64'(axi.WVALID), 64'(1));
    checkOutput("t1_awaddr", 64'(axi.AWADDR), 64'h1000);
    checkOutput("t1_wdata", 64'(axi.WDATA), 64'hDEAD_BEEF);
    checkOutput("t1_wstrb", 64'(axi.WSTRB), 64'hF);
    tick();
    checkOutput("t1_awvalid_drop", 64'(axi.AWVALID), 64'(0));
    checkOutput("t1_wvalid_drop", 64'(axi.WVALID), 64'(0));
    axi.BVALID = 1'b1;
    axi.BRESP  = OKAY;
    #1 checkOutput("t1_bready", 64'(axi.BREADY), 64'(1));
    tick();
    axi.BVALID = 1'b0;
    checkOutput("t1_rsp_valid", 64'(rsp_valid), 64'(1));
    checkOutput("t1_rsp_resp", 64'(rsp_resp), 64'(0));
    tick();
    checkOutput("t1_rsp_drop", 64'(rsp_valid), 64'(0));

    // W stalled five cycles while AW completes immediately
    axi.WREADY = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_2000;
    req_wdata  = 32'h1234_5678;
    req_wstrb  = 4'h3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_wvalid_held", 64'(axi.WVALID), 64'(1));
      checkOutput("t2_wdata_stable", 64'(axi.WDATA), 64'h1234_5678);
      checkOutput("t2_req_ready_low", 64'(req_ready), 64'(0));
      if (i > 0) checkOutput("t2_aw_done", 64'(axi.AWVALID), 64'(0));
      tick();
    end
    axi.WREADY = 1'b1;
    #1 checkOutput("t2_req_ready_on_w_hs", 64'(req_ready), 64'(1));
    tick();
    checkOutput("t2_wvalid_drop", 64'(axi.WVALID), 64'(0));
    pop_base   = pop_n;
    axi.BVALID = 1'b1;
    axi.BRESP  = EXOKAY;
    tick();
    axi.BVALID = 1'b0;
    checkOutput("t2_rsp_resp", 64'(rsp_resp), 64'(1));
    tick();
    tick();
    checkOutput("t2_single_rsp", 64'(pop_n - pop_base), 64'(1));

    // Outstanding limit: six requests offered with B withheld
    acc_base = acc_n;
    pop_base = pop_n;
    req_left = 6;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0);
      tick();
    end
    checkOutput("t3_accepts_at_limit", 64'(acc_n - acc_base), 64'(4));
    checkOutput("t3_req_ready_low", 64'(req_ready), 64'(0));
    for (int i = 0; i < 60 && (pop_n - pop_base) < 6; i++) begin
      applyStimulus(1'b0, 1'b1);
      tick();
    end
    req_valid  = 1'b0;
    axi.BVALID = 1'b0;
    checkOutput("t3_total_accepts", 64'(acc_n - acc_base), 64'(6));
    checkOutput("t3_total_rsps", 64'(pop_n - pop_base), 64'(6));

    // Local backpressure holds SLVERR; clear races a DECERR
    rsp_ready   = 1'b0;
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    req_valid   = 1'b1;
    req_addr    = 32'h0000_3000;
    req_wdata   = 32'hA5A5_0001;
    req_wstrb   = 4'h0;
    tick();
    req_addr    = 32'h0000_3004;
    req_wdata   = 32'hA5A5_0002;
    tick();
    req_valid   = 1'b0;
    axi.BVALID  = 1'b1;
    axi.BRESP   = SLVERR;
    tick();
    axi.BRESP   = DECERR;
    #1;
    checkOutput("t4_bready_low", 64'(axi.BREADY), 64'(0));
    checkOutput("t4_rsp_valid", 64'(rsp_valid), 64'(1));
    checkOutput("t4_rsp_slverr", 64'(rsp_resp), 64'(2));
`ifdef AXILM_WR_ERR_CNT_EN
    checkOutput("t4_err_cnt_one", 64'(err_cnt), 64'(1));
`endif
    tick();
    checkOutput("t4_rsp_slverr_held", 64'(rsp_resp), 64'(2));
    checkOutput("t4_bready_still_low", 64'(axi.BREADY), 64'(0));
    rsp_ready = 1'b1;
`ifdef AXILM_WR_ERR_CNT_EN
    err_clr = 1'b1;
`endif
    #1 checkOutput("t4_bready_on_pop", 64'(axi.BREADY), 64'(1));
    tick();
`ifdef AXILM_WR_ERR_CNT_EN
    err_clr = 1'b0;
    checkOutput("t4_err_cleared", 64'(err_cnt), 64'(0));
`endif
    axi.BVALID = 1'b0;
    checkOutput("t4_rsp_decerr", 64'(rsp_resp), 64'(3));
    tick();
    checkOutput("t4_rsp_drained", 64'(rsp_valid), 64'(0));

    // Reset in the middle of traffic: 3 in flight, AW stalled
    axi.BVALID = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_4000;
    tick();
    req_addr   = 32'h0000_4004;
    tick();
    req_addr   = 32'h0000_4008;
    tick();
    req_valid   = 1'b0;
    axi.AWREADY = 1'b0;
    tick();
    checkOutput("t5_pre_awvalid", 64'(axi.AWVALID), 64'(1));
    #2 ARESETn = 1'b0;
    #1;
    checkOutput("t5_awvalid_clr", 64'(axi.AWVALID), 64'(0));
    checkOutput("t5_wvalid_clr", 64'(axi.WVALID), 64'(0));
    checkOutput("t5_bready_clr", 64'(axi.BREADY), 64'(0));
    checkOutput("t5_rsp_valid_clr", 64'(rsp_valid), 64'(0));
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    resetModel();
    acc_base = acc_n;
    pop_base = pop_n;
    req_left = 4;
    applyStimulus(1'b0, 1'b0);
    #1 checkOutput("t5_first_req_ready", 64'(req_ready), 64'(1));
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      tick();
    end
    checkOutput("t5_cnt_cleared", 64'(acc_n - acc_base), 64'(4));
    for (int i = 0; i < 40 && (pop_n - pop_base) < 4; i++) begin
      applyStimulus(1'b0, 1'b1);
      tick();
    end
    req_valid  = 1'b0;
    axi.BVALID = 1'b0;
    checkOutput("t5_drained", 64'(pop_n - pop_base), 64'(4));

    // Randomized traffic against the model
    acc_base = acc_n;
    pop_base = pop_n;
    req_left = 60;
    for (int i = 0; i < 4000 && (pop_n - pop_base) < 60; i++) begin
      applyStimulus(1'b1, 1'b1);
      tick();
    end
    req_valid  = 1'b0;
    axi.BVALID = 1'b0;
    checkOutput("rand_accepts", 64'(acc_n - acc_base), 64'(60));
    checkOutput("rand_rsps", 64'(pop_n - pop_base), 64'(60));
    checkOutput("rand_queues_empty", 64'(q_addr.size() + q_w.size() + q_rsp.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axilm_wr_pipe.md
Name: axilm_wr_pipe

Overview:
- Parametrised AXI4-Lite write master. Successor of the single-shot write-channel FSM.
- Accepts local write requests over a valid/ready handshake and issues AW and W independently.
- Supports up to MAX_OUTS writes in flight and returns each BRESP to the local side through a registered response handshake.
- Sits between local bus masters (CPU/DMA glue) and the AXI-Lite interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 or 64; STRB_W = DATA_W/8.
- MAX_OUTS, 4, maximum accepted-but-unreturned writes; range 1..15.
- PROT, 3'b000, constant driven on AWPROT.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- AWADDR  out  ADDR_W  write address
- AWPROT  out  3  constant PROT
- AWVALID  out  1  address valid
- AWREADY  in  1  address ready
- WDATA  out  DATA_W  write data
- WSTRB  out  STRB_W  byte strobes
- WVALID  out  1  data valid
- WREADY  in  1  data ready
- BVALID  in  1  response valid
- BREADY  out  1  response ready
- BRESP  in  2  response code
- req_valid  in  1  local write request
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  request data
- req_wstrb  in  STRB_W  request strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  local consumer ready
- rsp_resp  out  2  BRESP of oldest completed write

Behaviour:
- Clocking/reset: one clock ACLK; reset ARESETn is asynchronous, active-low.
- Reset values: AWVALID=0, WVALID=0, BREADY=0, rsp_valid=0, AWADDR=0, WDATA=0, WSTRB=0, rsp_resp=2'b00, outstanding count=0. Reset mid-transaction drops all valids immediately and discards in-flight state; no response is generated for discarded writes.
- AW slot and W slot are independent holding registers.
  - A slot is "free" when its valid is low, or when its valid and ready are both high this cycle.
- req_ready = AW slot free & W slot free & (cnt < MAX_OUTS), or cnt == MAX_OUTS with a response pop this cycle. req_ready is combinational from slot/ready/count state; it has no dependency on req_valid.
- Accept (req_valid & req_ready):
  - Next edge loads AWADDR=req_addr and WDATA/WSTRB=req_wdata/req_wstrb, and sets AWVALID=1 and WVALID=1. Request-to-AWVALID latency is 1 cycle.
  - A request with req_wstrb==0 is still issued on AXI (no filtering).
- Each valid stays high with its payload stable until its own handshake.
  - A slot's valid clears after its handshake unless a new accept reloads that slot in the same cycle (back-to-back issue, one write per cycle sustained).
  - AW and W may complete in either order or in the same cycle.
- cnt counts writes from accept until rsp handshake: +1 on accept, -1 on rsp_valid & rsp_ready. Both events in one cycle leave cnt unchanged. cnt never exceeds MAX_OUTS.
- BREADY = ~rsp_valid | rsp_ready (registered-free path). On BVALID & BREADY: rsp_valid=1 and rsp_resp=BRESP at the next edge. rsp_valid otherwise clears on rsp handshake.
- BVALID arriving before both AW and W handshakes of the oldest write is a slave protocol error. It is not checked and the response is forwarded.
- MAX_OUTS=1 reproduces strict one-at-a-time behaviour: the next accept is possible only in the cycle the previous response is popped.

Optional Feature:
- Macro: AXILM_WR_ERR_CNT_EN.
- With macro defined:
  - Adds output port err_cnt [15:0], reset 0.
  - err_cnt increments on every B handshake with BRESP[1]==1 (SLVERR/DECERR) and saturates at 16'hFFFF.
  - Adds input err_clr (1 bit), which synchronously zeroes err_cnt; clear wins over a same-cycle increment.
- Without macro: neither port exists and there is no counter logic; all other behaviour is identical.

Decomposition:
- Package axilm_pkg:
  - resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - PROT default constant.
  - Function computing strobe width from data width.
- Sub-module axilm_ch_slot: a parametrised valid/payload holding register with load/handshake/free logic. Instantiated twice (AW payload ADDR_W; W payload DATA_W+STRB_W).

Test Plan:
- AWREADY=WREADY=1, BVALID driven the cycle after W, rsp_ready=1. Request addr 0x1000, data 0xDEADBEEF, strb 0xF -> AWVALID/WVALID high 1 cycle after accept, each for 1 cycle; rsp_valid with rsp_resp=00 one cycle after B handshake.
- WREADY held 0 for 5 cycles, AWREADY=1 -> AW completes first, WVALID stays high with WDATA stable, req_ready=0 until W handshake; single response returned.
- MAX_OUTS=4, BVALID withheld, 6 requests offered -> exactly 4 accepted and req_ready low after the 4th. Releasing B and popping responses in order returns 4 responses and accepts the remaining 2.
- rsp_ready=0 with BVALID=1 -> BREADY=0 while rsp_valid=1; BRESP=10 is held on rsp_resp until popped. With AXILM_WR_ERR_CNT_EN, err_cnt=1 afterwards; err_clr pulsed in the same cycle as a DECERR B handshake -> err_cnt=0.
- ARESETn asserted with AWVALID=1 and cnt=3 -> all valids and BREADY low immediately, cnt=0; first request after release is accepted normally.
